// File: rtl/sc_regserial_pkg.sv
// Shared types and constants for the general-register serial readback path.
package sc_regserial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } txState_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // 50 MHz system clock / 115200 baud
    localparam int DEFAULT_BAUD_DIV = 434;

endpackage

// File: rtl/sc_regserial_tx_baudtick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last and
// second-to-last cycle of each bit. Holding clear keeps the count at 0, so
// the first cycle after clear drops is count 0 of a fresh bit period.
module sc_baudtick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    output logic tick,
    output logic preTick
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] count;

    assign tick    = !clear && (count == CW'(BAUD_DIV - 1));
    assign preTick = !clear && (count == CW'(BAUD_DIV - 2));

    // Free-running bit counter, wraps at the end of every bit period
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sc_regserial_tx.sv
// Serial readback transmitter for the general register: on a falling edge of
// the active-low request it latches the parallel bus and sends
// start / DATAWIDTH data bits LSB-first / stop, each BAUD_DIV clocks long.
// Define SC_REGSERIALTX_PARITY_EN to insert an even-parity bit before stop.
module sc_regserial_tx
    import sc_regserial_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV
) (
    input  logic                 SC_RegSERIALTX_CLOCK_50,
    input  logic                 SC_RegSERIALTX_RESET_InLow,
    input  logic [DATAWIDTH-1:0] SC_RegSERIALTX_data_InBUS,
    input  logic                 SC_RegSERIALTX_start_InLow,
    output logic                 SC_RegSERIALTX_serial_Out,
    output logic                 SC_RegSERIALTX_busy_OutHigh,
    output logic                 SC_RegSERIALTX_done_OutHigh
);

    localparam int BCW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATAWIDTH - 1);

    txState_t             state;
    logic [DATAWIDTH-1:0] shiftReg;
    logic [BCW-1:0]       bitCnt;
    logic                 startPrev;
    logic                 request;
    logic                 baudClear;
    logic                 baudTick;
    logic                 baudPreTick;
`ifdef SC_REGSERIALTX_PARITY_EN
    logic                 parityBit;
`endif

    // Only a high-to-low transition counts; a held-low request is ignored
    assign request   = startPrev && !SC_RegSERIALTX_start_InLow;
    // Timer sits at zero while idle so the start bit gets a full period
    assign baudClear = (state == IDLE);

    sc_baudtick #(
        .BAUD_DIV (BAUD_DIV)
    ) uBaud (
        .clk     (SC_RegSERIALTX_CLOCK_50),
        .rstN    (SC_RegSERIALTX_RESET_InLow),
        .clear   (baudClear),
        .tick    (baudTick),
        .preTick (baudPreTick)
    );

    // Frame sequencer; every output is registered so the line is glitch-free
    always_ff @(posedge SC_RegSERIALTX_CLOCK_50 or negedge SC_RegSERIALTX_RESET_InLow) begin
        if (!SC_RegSERIALTX_RESET_InLow) begin
            state                       <= IDLE;
            shiftReg                    <= '0;
            bitCnt                      <= '0;
            startPrev                   <= 1'b1;
            SC_RegSERIALTX_serial_Out   <= LINE_IDLE;
            SC_RegSERIALTX_busy_OutHigh <= 1'b0;
            SC_RegSERIALTX_done_OutHigh <= 1'b0;
`ifdef SC_REGSERIALTX_PARITY_EN
            parityBit                   <= 1'b0;
`endif
        end else begin
            startPrev                   <= SC_RegSERIALTX_start_InLow;
            SC_RegSERIALTX_done_OutHigh <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        shiftReg                    <= SC_RegSERIALTX_data_InBUS;
                        bitCnt                      <= '0;
                        state                       <= START;
                        SC_RegSERIALTX_serial_Out   <= LINE_START;
                        SC_RegSERIALTX_busy_OutHigh <= 1'b1;
`ifdef SC_REGSERIALTX_PARITY_EN
                        parityBit                   <= ^SC_RegSERIALTX_data_InBUS;
`endif
                    end
                end
                START: begin
                    if (baudTick) begin
                        state                     <= DATA;
                        SC_RegSERIALTX_serial_Out <= shiftReg[0];
                        shiftReg                  <= shiftReg >> 1;
                    end
                end
                DATA: begin
                    if (baudTick) begin
                        if (bitCnt == LAST_BIT) begin
                            bitCnt <= '0;
`ifdef SC_REGSERIALTX_PARITY_EN
                            state                     <= PARITY;
                            SC_RegSERIALTX_serial_Out <= parityBit;
`else
                            state                     <= STOP;
                            SC_RegSERIALTX_serial_Out <= LINE_IDLE;
`endif
                        end else begin
                            bitCnt                    <= bitCnt + 1'b1;
                            SC_RegSERIALTX_serial_Out <= shiftReg[0];
                            shiftReg                  <= shiftReg >> 1;
                        end
                    end
                end
`ifdef SC_REGSERIALTX_PARITY_EN
                PARITY: begin
                    if (baudTick) begin
                        state                     <= STOP;
                        SC_RegSERIALTX_serial_Out <= LINE_IDLE;
                    end
                end
`endif
                STOP: begin
                    // Raised one cycle early so done lines up with the last busy cycle
                    if (baudPreTick) begin
                        SC_RegSERIALTX_done_OutHigh <= 1'b1;
                    end
                    if (baudTick) begin
                        state                       <= IDLE;
                        SC_RegSERIALTX_busy_OutHigh <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_regserial_tx.sv
// Bench for sc_regserial_tx (BAUD_DIV=4, DATAWIDTH=8). A frame-level model
// predicts line/busy/done every cycle; directed frames pin literal waveforms.
// Honours SC_REGSERIALTX_PARITY_EN like the design.
module tb_sc_regserial_tx;

    localparam int B = 4;
    localparam int W = 8;
`ifdef SC_REGSERIALTX_PARITY_EN
    localparam int NBITS = W + 3;
    localparam logic [10:0] EXP_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] EXP_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] EXP_C3 = 11'b1_0_11000011_0;
`else
    localparam int NBITS = W + 2;
    localparam logic [10:0] EXP_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] EXP_07 = 11'b0_1_00000111_0;
    localparam logic [10:0] EXP_C3 = 11'b0_1_11000011_0;
`endif
    localparam int FRAME = NBITS * B;

    logic         clk = 1'b0;
    logic         rstN = 1'b1;
    logic [W-1:0] data = '0;
    logic         start = 1'b1;
    logic         serial;
    logic         busy;
    logic         done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sc_regserial_tx #(
        .DATAWIDTH (W),
        .BAUD_DIV  (B)
    ) dut (
        .SC_RegSERIALTX_CLOCK_50     (clk),
        .SC_RegSERIALTX_RESET_InLow  (rstN),
        .SC_RegSERIALTX_data_InBUS   (data),
        .SC_RegSERIALTX_start_InLow  (start),
        .SC_RegSERIALTX_serial_Out   (serial),
        .SC_RegSERIALTX_busy_OutHigh (busy),
        .SC_RegSERIALTX_done_OutHigh (done)
    );

    // Frame model: mPos is the index of the current cycle inside a frame, -1 when idle
    int           mPos;
    logic         mPrev;
    logic [W-1:0] mData;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mPos  <= -1;
            mPrev <= 1'b1;
            mData <= '0;
        end else begin
            mPrev <= start;
            if (mPos >= 0) begin
                mPos <= (mPos == FRAME - 1) ? -1 : mPos + 1;
            end else if (mPrev && !start) begin
                mPos  <= 0;
                mData <= data;
            end
        end
    end

    function automatic logic frameBit(input int pos, input logic [W-1:0] d);
        int idx;
        idx = pos / B;
        if (idx == 0) return 1'b0;
        if (idx <= W) return d[idx-1];
`ifdef SC_REGSERIALTX_PARITY_EN
        if (idx == W + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitorCycle();
        logic eSer, eBusy, eDone;
        if (mPos < 0) begin
            eSer = 1'b1; eBusy = 1'b0; eDone = 1'b0;
        end else begin
            eSer  = frameBit(mPos, mData);
            eBusy = 1'b1;
            eDone = (mPos == FRAME - 1);
        end
        check("mon_serial", {31'd0, serial}, {31'd0, eSer});
        check("mon_busy",   {31'd0, busy},   {31'd0, eBusy});
        check("mon_done",   {31'd0, done},   {31'd0, eDone});
    endtask

    // Call before busy rises; records mid-bit line samples of one frame
    task automatic captureFrame(output int nBusy, output int nDone, output logic [10:0] seen);
        int waitC;
        nBusy = 0; nDone = 0; seen = '0; waitC = 0;
        do begin
            @(negedge clk);
            waitC++;
        end while (!busy && waitC < 20);
        if (!busy) begin
            check("frame_start_timeout", 32'd0, 32'd1);
            return;
        end
        while (busy && nBusy < 200) begin
            if ((nBusy % B) == 1 && (nBusy / B) < 11) seen[nBusy/B] = serial;
            if (done) nDone++;
            nBusy++;
            @(negedge clk);
        end
        check("done_after_frame", {31'd0, done}, 32'd0);
    endtask

    task automatic drive(input logic s, input logic [W-1:0] d);
        @(posedge clk);
        #2;
        start = s;
        data  = d;
    endtask

    initial begin
        int nB, nD, cnt, dn;
        logic [10:0] seen;

        #1 rstN = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitorCycle();
            end
        join_none

        // Reset held with request toggling
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 8'hFF);
            @(negedge clk);
            check("reset_serial", {31'd0, serial}, 32'd1);
            check("reset_busy",   {31'd0, busy},   32'd0);
            check("reset_done",   {31'd0, done},   32'd0);
        end
        drive(1'b1, 8'h00);
        rstN = 1'b1;
        drive(1'b1, 8'h00);

        // Basic frame 0xA5
        drive(1'b0, 8'hA5);
        captureFrame(nB, nD, seen);
        check("a5_bits", {21'd0, seen}, {21'd0, EXP_A5});
        check("a5_busy_len", nB, FRAME);
        check("a5_done_cnt", nD, 1);
        drive(1'b1, 8'h00);

        // Parity-relevant pattern 0x07
        drive(1'b0, 8'h07);
        captureFrame(nB, nD, seen);
        check("x07_bits", {21'd0, seen}, {21'd0, EXP_07});
        check("x07_busy_len", nB, FRAME);
        drive(1'b1, 8'h00);

        // Busy lockout: new edge and new data mid-frame
        drive(1'b0, 8'hA5);
        fork
            captureFrame(nB, nD, seen);
            begin
                drive(1'b1, 8'hA5);
                repeat (8) @(posedge clk);
                drive(1'b0, 8'h3C);
                drive(1'b1, 8'h3C);
            end
        join
        check("lock_bits", {21'd0, seen}, {21'd0, EXP_A5});
        check("lock_done_cnt", nD, 1);
        repeat (3) @(posedge clk);
        check("lock_no_queue", {31'd0, busy}, 32'd0);

        // Held request: one frame only
        drive(1'b0, 8'h5A);
        cnt = 0; dn = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            if (done) dn++;
            if (i == 100) begin
                @(posedge clk);
                #2 start = 1'b1;
            end
        end
        check("held_busy_len", cnt, FRAME);
        check("held_done_cnt", dn, 1);

        // Back-to-back: request in the idle cycle right after done
        drive(1'b0, 8'h81);
        drive(1'b1, 8'h81);
        cnt = 0;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_done_seen", {31'd0, done}, 32'd1);
        drive(1'b0, 8'h3C);
        @(negedge clk);
        check("b2b_gap_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b_restart_busy", {31'd0, busy}, 32'd1);
        check("b2b_restart_line", {31'd0, serial}, 32'd0);
        drive(1'b1, 8'h00);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end

        // Reset during data bit 3
        drive(1'b0, 8'h5A);
        dn = 0;
        @(posedge clk);
        repeat (17) begin
            @(posedge clk);
            if (done) dn++;
        end
        #3 rstN = 1'b0;
        start = 1'b1;
        #1;
        check("midrst_serial", {31'd0, serial}, 32'd1);
        check("midrst_busy",   {31'd0, busy},   32'd0);
        check("midrst_done",   {31'd0, done | (dn != 0)}, 32'd0);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h00);
        rstN = 1'b1;
        drive(1'b1, 8'h00);
        drive(1'b0, 8'hC3);
        captureFrame(nB, nD, seen);
        check("post_rst_bits", {21'd0, seen}, {21'd0, EXP_C3});
        check("post_rst_done_cnt", nD, 1);
        drive(1'b1, 8'h00);

        // Random requests, data churn and rare async resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            rstN  = 1'b1;
            start = ($urandom_range(0, 5) != 0);
            data  = W'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #1 rstN = 1'b0;
            end
        end
        drive(1'b1, 8'h00);
        rstN = 1'b1;
        repeat (FRAME + 4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
